// File: rtl/change_event_fifo_if.sv
// Event-in / byte-out bundle for change_event_fifo.
// The FIFO itself sits on the slave side, and the event source or sink sits on the master side.
interface change_event_fifo_if #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
);
  logic                     evt_valid;
  logic [1:0]               evt_chan;
  logic [7:0]               evt_data;
  logic                     out_ready;
  logic                     out_valid;
  logic [7:0]               out_byte;
  logic [$clog2(DEPTH):0]   fifo_count;
  logic                     overflow;
  logic [DROP_W-1:0]        drop_cnt;

  modport master (
    output evt_valid, evt_chan, evt_data, out_ready,
    input  out_valid, out_byte, fifo_count, overflow, drop_cnt
  );

  modport slave (
    input  evt_valid, evt_chan, evt_data, out_ready,
    output out_valid, out_byte, fifo_count, overflow, drop_cnt
  );
endinterface

// File: rtl/change_event_fifo.sv
// Buffers change events and serializes each one as two bytes:
// first a header {2'b10, chan, seq}, then the data byte.
module change_event_fifo #(
  parameter int DEPTH  = 8,
  parameter int DROP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,   // active-high despite the name
  change_event_fifo_if.slave bus
);
  // state | meaning
  // IDLE  | nothing presented, out_byte = 8'h00
  // HDR   | header byte of the head entry presented
  // DATA  | data byte of the head entry presented, popped on handshake

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [13:0]       mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     count;
  logic [3:0]        seq;
  logic              overflow;
  logic [DROP_W-1:0] drop_cnt;
  logic              full;
  logic              push;
  logic              pop;
  logic              drop;
  logic [13:0]       head;

  // Entry layout: {chan[13:12], data[11:4], seq[3:0]}
  assign full = (count == CW'(DEPTH));
  assign pop  = (state == DATA) && bus.out_ready;
  assign push = bus.evt_valid && (!full || pop);
  assign drop = bus.evt_valid && full && !pop;
  assign head = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push && !rst_n) begin
      mem[wr_ptr] <= {bus.evt_chan, bus.evt_data, seq};
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      seq      <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
        seq    <= seq + 4'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != {DROP_W{1'b1}}) begin
          drop_cnt <= drop_cnt + DROP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The DATA exit uses the count from before the pop.
  // A push on the last pop therefore still goes through IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (count != '0) state_nxt = HDR;
      HDR:  if (bus.out_ready) state_nxt = DATA;
      DATA: if (bus.out_ready) state_nxt = (count > CW'(1)) ? HDR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.out_valid = 1'b0;
    bus.out_byte  = 8'h00;
    case (state)
      HDR: begin
        bus.out_valid = 1'b1;
        bus.out_byte  = {2'b10, head[13:12], head[3:0]};
      end
      DATA: begin
        bus.out_valid = 1'b1;
        bus.out_byte  = head[11:4];
      end
      default: ;
    endcase
  end

  assign bus.fifo_count = count;
  assign bus.overflow   = overflow;
  assign bus.drop_cnt   = drop_cnt;
endmodule

// File: tb/tb_change_event_fifo.sv
// Directed and random stimulus for change_event_fifo.
// Checking uses a queue-based event model that predicts the byte stream.
module tb_change_event_fifo;
  localparam int DEPTH  = 8;
  localparam int DROP_W = 8;
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  change_event_fifo_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus ();

  change_event_fifo #(.DEPTH(DEPTH), .DROP_W(DROP_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model: queue of stored events {chan, data, seq} plus the byte position within the head event
  logic [13:0] mq[$];
  int          m_idx;
  int          m_seq;
  int          m_drops;
  logic        m_ovf;
  int          bytes_seen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    m_idx   = 0;
    m_seq   = 0;
    m_drops = 0;
    m_ovf   = 1'b0;
  endtask

  // One clock: drive inputs, check the presented byte, advance the model, then check the status outputs.
  task automatic cycle(input bit v, input logic [1:0] c, input logic [7:0] d, input bit rdy);
    bit          hs;
    bit          pop;
    logic [7:0]  exp_byte;
    bus.evt_valid = v;
    bus.evt_chan  = c;
    bus.evt_data  = d;
    bus.out_ready = rdy;
    hs  = bus.out_valid && rdy;
    pop = 1'b0;
    if (mq.size() == 0) begin
      check("empty_valid", {31'd0, bus.out_valid}, 32'd0);
      check("empty_byte", {24'd0, bus.out_byte}, 32'd0);
    end else if (bus.out_valid) begin
      exp_byte = (m_idx == 0) ? {2'b10, mq[0][13:12], mq[0][3:0]} : mq[0][11:4];
      check(m_idx == 0 ? "hdr_byte" : "data_byte", {24'd0, bus.out_byte}, {24'd0, exp_byte});
      if (hs) begin
        bytes_seen++;
        if (m_idx == 1) pop = 1'b1;
        m_idx = 1 - m_idx;
      end
    end
    if (v) begin
      if (mq.size() < DEPTH || pop) begin
        mq.push_back({c, d, 4'(m_seq)});
        m_seq = (m_seq + 1) % 16;
      end else begin
        m_ovf = 1'b1;
        if (m_drops < DROP_MAX) m_drops++;
      end
    end
    if (pop) void'(mq.pop_front());
    @(posedge clk);
    #1;
    check("fifo_count", {28'd0, bus.fifo_count}, mq.size());
    check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
    check("drop_cnt", {24'd0, bus.drop_cnt}, m_drops);
  endtask

  task automatic do_reset();
    rst_n = 1'b1;
    bus.evt_valid = 1'b1;   // events during reset must be ignored
    bus.evt_chan  = 2'd3;
    bus.evt_data  = 8'hEE;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("rst_byte", {24'd0, bus.out_byte}, 32'd0);
    check("rst_count", {28'd0, bus.fifo_count}, 32'd0);
    check("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    check("rst_drops", {24'd0, bus.drop_cnt}, 32'd0);
    rst_n = 1'b0;
    bus.evt_valid = 1'b0;
    model_clear();
  endtask

  task automatic drain();
    for (int i = 0; i < 400; i++) begin
      if (mq.size() == 0 && !bus.out_valid) break;
      cycle(1'b0, 2'd0, 8'd0, 1'b1);
    end
    check("drain_model_empty", mq.size(), 32'd0);
    check("drain_count", {28'd0, bus.fifo_count}, 32'd0);
    check("drain_valid", {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    bus.evt_valid = 1'b0;
    bus.evt_chan  = 2'd0;
    bus.evt_data  = 8'd0;
    bus.out_ready = 1'b0;
    model_clear();
    bytes_seen = 0;
    #1;

    // Single event: header A0 one edge after the push, then 5A
    do_reset();
    cycle(1'b1, 2'd2, 8'h5A, 1'b1);
    check("single_lat0_valid", {31'd0, bus.out_valid}, 32'd0);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    check("single_hdr_valid", {31'd0, bus.out_valid}, 32'd1);
    check("single_hdr", {24'd0, bus.out_byte}, 32'hA0);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    check("single_data", {24'd0, bus.out_byte}, 32'h5A);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    check("single_done_valid", {31'd0, bus.out_valid}, 32'd0);

    // Backpressure on a pending header
    do_reset();
    cycle(1'b1, 2'd2, 8'h3C, 1'b0);
    cycle(1'b0, 2'd0, 8'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 2'd0, 8'd0, 1'b0);
      check("bp_valid", {31'd0, bus.out_valid}, 32'd1);
      check("bp_byte", {24'd0, bus.out_byte}, 32'hA0);
    end
    drain();

    // Fill and drop, then a push coinciding with the data-byte pop of a full FIFO
    do_reset();
    for (int i = 0; i < 10; i++) cycle(1'b1, 2'(i), 8'($urandom), 1'b0);
    check("fill_count", {28'd0, bus.fifo_count}, 32'd8);
    check("fill_drops", {24'd0, bus.drop_cnt}, 32'd2);
    check("fill_ovf", {31'd0, bus.overflow}, 32'd1);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    cycle(1'b1, 2'd3, 8'hC3, 1'b1);
    check("full_pp_count", {28'd0, bus.fifo_count}, 32'd8);
    check("full_pp_drops", {24'd0, bus.drop_cnt}, 32'd2);
    drain();

    // Wrap-around: 20 events streamed with no drops
    do_reset();
    bytes_seen = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 2'($urandom), 8'($urandom), 1'b1);
      cycle(1'b0, 2'd0, 8'd0, 1'b1);
      cycle(1'b0, 2'd0, 8'd0, 1'b1);
    end
    drain();
    check("wrap_bytes", bytes_seen, 32'd40);
    check("wrap_drops", {24'd0, bus.drop_cnt}, 32'd0);

    // Reset mid-operation while DATA is presented with three events stored
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 2'(i), 8'($urandom), 1'b0);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    check("mid_in_data_count", {28'd0, bus.fifo_count}, 32'd3);
    #2;
    rst_n = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check("mid_rst_byte", {24'd0, bus.out_byte}, 32'd0);
    check("mid_rst_count", {28'd0, bus.fifo_count}, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    model_clear();
    cycle(1'b1, 2'd1, 8'h77, 1'b1);
    cycle(1'b0, 2'd0, 8'd0, 1'b1);
    check("post_rst_hdr", {24'd0, bus.out_byte}, 32'h90);
    drain();

    // Drop counter saturation
    do_reset();
    for (int i = 0; i < DEPTH + 260; i++) cycle(1'b1, 2'($urandom), 8'($urandom), 1'b0);
    check("sat_drops", {24'd0, bus.drop_cnt}, DROP_MAX);
    drain();

    // Random traffic
    do_reset();
    for (int i = 0; i < 600; i++) begin
      cycle(1'(($urandom_range(0, 99) < 45) ? 1 : 0), 2'($urandom), 8'($urandom),
            1'(($urandom_range(0, 99) < 65) ? 1 : 0));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
